// File: rtl/rst_seq.sv
`default_nettype none
// ============================================================================
// Module : rst_seq
// Brief  : Staged, index-ordered release of NCH active-low resets, restarted
//          by a debounced push button or a link-down edge.
// Rev    : 1.0
// ============================================================================
module rst_seq #(
    parameter int NCH     = 3,
    parameter int STEP_W  = 21,
    parameter int DEB_W   = 16,
    parameter int LINKMON = 1
) (
    input  logic           pcie_clk,
    input  logic           sys_rst,
    input  logic           btn,
    input  logic           link_up,
    output logic [NCH-1:0] rst_n_out,
    output logic           seq_done,
    output logic [7:0]     restart_cnt
);

    localparam int                 c_idx_w = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [NCH-1:0]     c_one   = NCH'(1);
    localparam logic [c_idx_w-1:0] c_last  = c_idx_w'(NCH - 1);

    typedef enum logic [1:0] {
        S_HOLD  = 2'd0,
        S_STAGE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    logic               r_btn_s1;
    logic               r_btn_s2;
    logic [DEB_W-1:0]   r_deb_cnt;
    logic               r_btn_db;
    logic               r_link_prev;
    state_t             r_state;
    logic [STEP_W-1:0]  r_step;
    logic [c_idx_w-1:0] r_idx;
    logic [NCH-1:0]     r_rst_n;
    logic [7:0]         r_restart_cnt;

    state_t             w_state_nxt;
    logic [STEP_W-1:0]  w_step_nxt;
    logic [c_idx_w-1:0] w_idx_nxt;
    logic [NCH-1:0]     w_rst_n_nxt;
    logic               w_press;
    logic               w_link_ev;
    logic               w_restart;
    logic               w_tc;

    // Press fires in the cycle whose edge moves btn_db from 1 to 0.
    assign w_press   = r_btn_db && !r_btn_s2 && (&r_deb_cnt);
    assign w_link_ev = (LINKMON != 0) && r_link_prev && !link_up;
    assign w_restart = w_press || w_link_ev;
    assign w_tc      = &r_step;

    always_ff @(posedge pcie_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_btn_s1    <= 1'b1;
            r_btn_s2    <= 1'b1;
            r_deb_cnt   <= '0;
            r_btn_db    <= 1'b1;
            r_link_prev <= 1'b0;
        end else begin
            r_btn_s1    <= btn;
            r_btn_s2    <= r_btn_s1;
            r_link_prev <= link_up;
            if (r_btn_s2 != r_btn_db) begin
                if (&r_deb_cnt) begin
                    r_btn_db  <= r_btn_s2;
                    r_deb_cnt <= '0;
                end else begin
                    r_deb_cnt <= r_deb_cnt + 1'b1;
                end
            end else begin
                r_deb_cnt <= '0;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_idx_nxt   = r_idx;
        w_rst_n_nxt = r_rst_n;
        if (w_restart) begin
            // Restart outranks a coincident terminal count.
            w_state_nxt = S_HOLD;
            w_step_nxt  = '0;
            w_idx_nxt   = '0;
            w_rst_n_nxt = '0;
        end else begin
            case (r_state)
                S_HOLD: begin
                    w_step_nxt  = r_step + 1'b1;
                    w_rst_n_nxt = '0;
                    if (w_tc) begin
                        w_rst_n_nxt = c_one;
                        w_idx_nxt   = c_idx_w'(1);
                        w_state_nxt = (NCH == 1) ? S_DONE : S_STAGE;
                    end
                end
                S_STAGE: begin
                    w_step_nxt = r_step + 1'b1;
                    if (w_tc) begin
                        w_rst_n_nxt = r_rst_n | (c_one << r_idx);
                        w_idx_nxt   = r_idx + 1'b1;
                        if (r_idx == c_last) begin
                            w_state_nxt = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    w_step_nxt = '0;
                end
                default: begin
                    w_state_nxt = S_HOLD;
                    w_step_nxt  = '0;
                    w_idx_nxt   = '0;
                    w_rst_n_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge pcie_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state       <= S_HOLD;
            r_step        <= '0;
            r_idx         <= '0;
            r_rst_n       <= '0;
            r_restart_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            r_idx   <= w_idx_nxt;
            r_rst_n <= w_rst_n_nxt;
            if (w_restart && (r_restart_cnt != 8'hFF)) begin
                r_restart_cnt <= r_restart_cnt + 1'b1;
            end
        end
    end

    assign rst_n_out   = r_rst_n;
    assign seq_done    = (r_state == S_DONE);
    assign restart_cnt = r_restart_cnt;

endmodule
`default_nettype wire

// File: doc/rst_seq.md
RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 SHALL have parameter NCH, default 3: number of sequenced reset channels, range 1..8.
REQ-002 SHALL have parameter STEP_W, default 21: step counter width; one release step = 2^STEP_W cycles, which is about 16.8 ms at 125 MHz.
REQ-003 SHALL have parameter DEB_W, default 16: debounce counter width; button stable time = 2^DEB_W cycles.
REQ-004 SHALL have parameter LINKMON, default 1: when 1, a falling edge on link_up restarts the sequence.
REQ-005 SHALL have port pcie_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port sys_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port btn, input, 1 bit: push button, active-low, asynchronous to pcie_clk.
REQ-008 SHALL have port link_up, input, 1 bit: link status, synchronous to pcie_clk.
REQ-009 SHALL have port rst_n_out, output, NCH bits: per-channel active-low resets, released in index order.
REQ-010 SHALL have port seq_done, output, 1 bit: all channels released.
REQ-011 SHALL have port restart_cnt, output, 8 bits: saturating count of restarts since sys_rst.

Function
REQ-012 SHALL pass btn through a 2-FF synchroniser; the synchroniser flops reset to 1.
REQ-013 SHALL hold the debounced level btn_db (reset value 1) and update it to the synchronised value only after that value has differed from btn_db for 2^DEB_W consecutive cycles; any bounce clears the debounce counter.
REQ-014 SHALL raise a one-cycle press event on each btn_db 1->0 transition; the 0->1 transition produces no event.
REQ-015 SHALL raise a one-cycle link event on each link_up 1->0 transition (registered previous value, reset 0) when LINKMON=1; when LINKMON=0 link_up is ignored.
REQ-016 SHALL implement FSM states: HOLD, STAGE, DONE.
REQ-017 In HOLD, SHALL keep all rst_n_out bits 0 and increment the step counter; at terminal count it SHALL set rst_n_out[0]=1 and set stage index idx=1. If NCH=1 it SHALL go to DONE; otherwise it SHALL go to STAGE.
REQ-018 In STAGE, SHALL set rst_n_out[idx]=1 at each step-counter terminal count and increment idx; when the channel just released is NCH-1 it SHALL go to DONE.
REQ-019 SHALL release channel k on the rising edge that ends cycle (k+1)*2^STEP_W, counting from the first rising edge after sys_rst deasserts or after a restart event.
REQ-020 SHALL drive seq_done=1 exactly in DONE; it SHALL rise on the same edge as rst_n_out[NCH-1].
REQ-021 On a restart event (press OR link event) in any state, SHALL on the next edge clear rst_n_out to 0, clear seq_done, clear the step counter and idx, and enter HOLD.
REQ-022 A restart event SHALL have priority over a terminal count in the same cycle, so no channel is released that cycle.
REQ-023 Press and link events in the same cycle SHALL count as one restart.
REQ-024 SHALL increment restart_cnt by 1 per restart, saturating at 255 with no wrap.
REQ-025 Once set during a sequence, rst_n_out bits SHALL never deassert except via restart or sys_rst.
REQ-026 The step counter SHALL wrap to 0 at each terminal count and SHALL hold at 0 in DONE.

Reset
REQ-027 While sys_rst=1, SHALL force: rst_n_out=0, seq_done=0, restart_cnt=0, state=HOLD, step counter 0, idx 0, debounce counter 0, btn_db=1.
REQ-028 Assertion of sys_rst mid-sequence SHALL immediately force all outputs low, asynchronously and without waiting for a clock edge.

Verification (NCH=3, STEP_W=2, DEB_W=2, LINKMON=1)
REQ-029 Release sys_rst -> rst_n_out=001 at cycle 4, 011 at cycle 8, 111 and seq_done=1 at cycle 12; all held thereafter.
REQ-030 Hold btn=0 for 10 cycles in DONE -> after 2 sync cycles plus 4 stable cycles, rst_n_out=000 and restart_cnt=1; then 001 appears 4 cycles later.
REQ-031 Toggle btn every 2 cycles for 20 cycles -> no press event, no restart, restart_cnt remains 0.
REQ-032 Drop link_up 1->0 in the same cycle as channel-1 terminal count -> rst_n_out stays 001 then goes to 000; the sequence restarts from HOLD.
REQ-033 Force 300 restarts -> restart_cnt=255.
REQ-034 Assert sys_rst at cycle 6 of a sequence -> rst_n_out=000 immediately; after release, timing is identical to REQ-029.
